// File: rtl/button_event_decoder_pkg.sv
// Shared types and constants for the button event decoder.
// Optional feature macro: BTN_DOUBLE_CLICK_EN (adds double-click detection).
package button_event_decoder_pkg;

    // Gesture FSM states; the double-click states only exist when the feature is built in.
    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
`ifdef BTN_DOUBLE_CLICK_EN
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
`else
        LONG_HELD      = 3'd2
`endif
    } state_t;

    // Event codes presented on event_code.
    localparam logic [1:0] EVT_NONE   = 2'd0;
    localparam logic [1:0] EVT_CLICK  = 2'd1;
    localparam logic [1:0] EVT_DOUBLE = 2'd2;
    localparam logic [1:0] EVT_LONG   = 2'd3;

    // Larger of two integers, used to size the elapsed-ms counter.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/button_event_decoder_ms_tick_gen.sv
// Restartable 1 ms prescaler: tick is high for one cycle every CLK_FREQ*1000
// cycles, the first one exactly CLK_FREQ*1000 cycles after a restart.
module ms_tick_gen #(
    parameter int CLK_FREQ = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV  = CLK_FREQ * 1000;
    localparam int          CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Cycle counter that wraps at the end of each millisecond or on restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/button_event_decoder.sv
// Button gesture decoder: turns a debounced button level into CLICK, LONG and
// (optionally) DOUBLE events with a valid/ready handshake and a sticky drop flag.
// Optional feature macro: BTN_DOUBLE_CLICK_EN.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int CLK_FREQ  = 50,
    parameter int LONG_MS   = 1000,
    parameter int DCLICK_MS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_level,
    output logic       event_valid,
    output logic [1:0] event_code,
    input  logic       event_ready,
    output logic       overflow,
    input  logic       overflow_clr
);

    localparam int MS_MAX = max_int(LONG_MS, DCLICK_MS);
    localparam int MS_W   = $clog2(MS_MAX + 1);

    state_t          state;
    state_t          state_nxt;
    logic            pb_prev;
    logic            rise;
    logic            fall;
    logic            tick;
    logic            restart;
    logic [MS_W-1:0] ms_cnt;
    logic            long_hit;
    logic            emit;
    logic [1:0]      emit_code;
    logic            accept;
    logic            drop;

    assign rise     = pb_level & ~pb_prev;
    assign fall     = ~pb_level & pb_prev;
    assign long_hit = tick && (ms_cnt == MS_W'(LONG_MS - 1));
`ifdef BTN_DOUBLE_CLICK_EN
    logic dclick_hit;
    assign dclick_hit = tick && (ms_cnt == MS_W'(DCLICK_MS - 1));
`endif

    // Every state change restarts both the prescaler and the ms count.
    assign restart = (state_nxt != state);
    assign accept  = event_valid && event_ready;
    assign drop    = emit && event_valid && !event_ready;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // Elapsed milliseconds in the current state; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt <= '0;
        end else if (restart) begin
            ms_cnt <= '0;
        end else if (tick && (ms_cnt != MS_W'(MS_MAX))) begin
            ms_cnt <= ms_cnt + MS_W'(1);
        end else begin
            ms_cnt <= ms_cnt;
        end
    end

    // Gesture decode: next state and which event (if any) this cycle triggers.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_code = EVT_NONE;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PRESSED: begin
                if (long_hit) begin
                    state_nxt = LONG_HELD;
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                end else if (fall) begin
`ifdef BTN_DOUBLE_CLICK_EN
                    state_nxt = WAIT_SECOND;
`else
                    state_nxt = IDLE;
                    emit      = 1'b1;
                    emit_code = EVT_CLICK;
`endif
                end else begin
                    state_nxt = PRESSED;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = LONG_HELD;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            WAIT_SECOND: begin
                if (rise) begin
                    state_nxt = SECOND_PRESSED;
                end else if (dclick_hit) begin
                    state_nxt = IDLE;
                    emit      = 1'b1;
                    emit_code = EVT_CLICK;
                end else begin
                    state_nxt = WAIT_SECOND;
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    state_nxt = IDLE;
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                end else if (long_hit) begin
                    state_nxt = LONG_HELD;
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                end else begin
                    state_nxt = SECOND_PRESSED;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, edge-detect sample and registered event/overflow outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pb_prev     <= 1'b0;
            event_valid <= 1'b0;
            event_code  <= EVT_NONE;
            overflow    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pb_prev <= pb_level;

            // A new event loads when the slot is empty or being emptied this cycle.
            if (emit && (!event_valid || event_ready)) begin
                event_valid <= 1'b1;
                event_code  <= emit_code;
            end else if (accept) begin
                event_valid <= 1'b0;
                event_code  <= EVT_NONE;
            end else begin
                event_valid <= event_valid;
                event_code  <= event_code;
            end

            // A drop wins over a simultaneous clear so no loss goes unreported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed self-checking bench for button_event_decoder (CLK_FREQ=1,
// LONG_MS=10, DCLICK_MS=4). Expectations follow BTN_DOUBLE_CLICK_EN.
module tb_button_event_decoder;

    logic       clk;
    logic       rst_n;
    logic       pb_level;
    logic       event_valid;
    logic [1:0] event_code;
    logic       event_ready;
    logic       overflow;
    logic       overflow_clr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ev_cyc[$];
    int ev_code[$];

`ifdef BTN_DOUBLE_CLICK_EN
    localparam int DLY = 4000;
`else
    localparam int DLY = 0;
`endif
    localparam int CLICK_LAT = DLY + 1;

    button_event_decoder #(
        .CLK_FREQ  (1),
        .LONG_MS   (10),
        .DCLICK_MS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pb_level     (pb_level),
        .event_valid  (event_valid),
        .event_code   (event_code),
        .event_ready  (event_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every accepted event with the cycle it was visible in.
    always @(negedge clk) begin
        if (rst_n && event_valid && event_ready) begin
            ev_cyc.push_back(cyc);
            ev_code.push_back(int'(event_code));
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        ev_cyc.delete();
        ev_code.delete();
    endtask

    int t1;
    int t2;

    initial begin
        rst_n        = 1'b0;
        pb_level     = 1'b0;
        event_ready  = 1'b1;
        overflow_clr = 1'b0;
        step(3);
        check_val("rst_valid", int'(event_valid), 0);
        check_val("rst_code", int'(event_code), 0);
        check_val("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        step(5);
        check_val("idle_valid", int'(event_valid), 0);

        // Single click.
        clear_log();
        pb_level = 1'b1;
        step(2000);
        pb_level = 1'b0;
        t1 = cyc;
        step(4100);
        check_val("click_count", ev_code.size(), 1);
        if (ev_code.size() >= 1) begin
            check_val("click_code", ev_code[0], 1);
            check_val("click_time", ev_cyc[0] - t1, CLICK_LAT);
        end

        // Double click.
        clear_log();
        pb_level = 1'b1;
        step(2000);
        pb_level = 1'b0;
        t1 = cyc;
        step(1000);
        pb_level = 1'b1;
        step(2000);
        pb_level = 1'b0;
        t2 = cyc;
        step(4100);
`ifdef BTN_DOUBLE_CLICK_EN
        check_val("dbl_count", ev_code.size(), 1);
        if (ev_code.size() >= 1) begin
            check_val("dbl_code", ev_code[0], 2);
            check_val("dbl_time", ev_cyc[0] - t2, 1);
        end
`else
        check_val("dbl_count", ev_code.size(), 2);
        if (ev_code.size() >= 2) begin
            check_val("dbl_code0", ev_code[0], 1);
            check_val("dbl_time0", ev_cyc[0] - t1, 1);
            check_val("dbl_code1", ev_code[1], 1);
            check_val("dbl_time1", ev_cyc[1] - t2, 1);
        end
`endif

        // Long press, no event at release.
        clear_log();
        pb_level = 1'b1;
        t1 = cyc;
        step(15000);
        pb_level = 1'b0;
        step(100);
        check_val("long_count", ev_code.size(), 1);
        if (ev_code.size() >= 1) begin
            check_val("long_code", ev_code[0], 3);
            check_val("long_time", ev_cyc[0] - t1, 10001);
        end

        // Back-pressure: first click held, second dropped with clear in the drop cycle.
        event_ready = 1'b0;
        pb_level = 1'b1;
        step(2000);
        pb_level = 1'b0;
        step(4100);
        check_val("bp_valid", int'(event_valid), 1);
        check_val("bp_code", int'(event_code), 1);
        check_val("bp_ovf0", int'(overflow), 0);
        pb_level = 1'b1;
        step(2000);
        pb_level = 1'b0;
        step(DLY);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check_val("drop_ovf_vs_clr", int'(overflow), 1);
        check_val("drop_code_held", int'(event_code), 1);
        step(10);
        check_val("ovf_sticky", int'(overflow), 1);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check_val("ovf_cleared", int'(overflow), 0);
        check_val("ovf_clr_valid", int'(event_valid), 1);
        clear_log();
        event_ready = 1'b1;
        step(1);
        event_ready = 1'b0;
        check_val("accept_valid", int'(event_valid), 0);
        check_val("accept_code", int'(event_code), 0);
        check_val("accept_count", ev_code.size(), 1);

        // Emit in the same cycle as an accept: new event replaces the old one.
        pb_level = 1'b1;
        step(10100);
        pb_level = 1'b0;
        step(10);
        check_val("pend_long_code", int'(event_code), 3);
        pb_level = 1'b1;
        step(2000);
        pb_level = 1'b0;
        step(DLY);
        event_ready = 1'b1;
        step(1);
        event_ready = 1'b0;
        check_val("swap_valid", int'(event_valid), 1);
        check_val("swap_code", int'(event_code), 1);
        check_val("swap_ovf", int'(overflow), 0);

        // Set overflow, then reset asynchronously mid-press.
        pb_level = 1'b1;
        step(2000);
        pb_level = 1'b0;
        step(4100);
        check_val("pre_rst_ovf", int'(overflow), 1);
        pb_level = 1'b1;
        step(500);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_valid", int'(event_valid), 0);
        check_val("async_code", int'(event_code), 0);
        check_val("async_ovf", int'(overflow), 0);
        pb_level = 1'b0;
        step(5);
        rst_n = 1'b1;
        event_ready = 1'b1;
        clear_log();
        step(6000);
        check_val("post_rst_count", ev_code.size(), 0);
        check_val("post_rst_valid", int'(event_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
